oam_dma_arbiter: RTL and testbench

//  Owns the FF46 OAM-DMA register and arbitrates the main memory bus (0000-FEFF) between the sm83

---
 rtl/oam_dma_arbiter.sv | 128 ++++++++++++
 tb/tb_oam_dma_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_arbiter.sv
// FF46 OAM-DMA register and main-bus arbiter between the core and the 160-byte OAM copy engine.
// The FF00-FFFF high port is never arbitrated, so the core can run from HRAM during a transfer.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter int unsigned XFER_LEN     = 160,
  parameter int unsigned START_DELAY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_write,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  hi_addr,
  output logic        hi_write,
  input  logic [7:0]  hi_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        dma_active
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_XFER} state_t;

  state_t             state_q, state_d;
  logic [7:0]         page_q, page_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [DLY_W-1:0]   dly_q, dly_d;

  logic       hi_sel;
  logic       reg_hit;
  logic       reg_wr;
  logic       active;
  logic [7:0] src;

  assign hi_sel  = (cpu_addr[15:8] == 8'hFF);
  assign reg_hit = (cpu_addr == DMA_REG_ADDR);
  assign reg_wr  = ce & cpu_write & reg_hit;
  assign active  = (state_q != ST_IDLE);
  // Echo-RAM fold: pages E0-FF source from C0-DF.
  assign src     = (page_q >= 8'hE0) ? (page_q & 8'hDF) : page_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      page_q  <= 8'h00;
      index_q <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      index_q <= index_d;
      dly_q   <= dly_d;
    end
  end

  // Next state; a register write in any state (re)starts the transfer and wins over completion.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    index_d = index_q;
    dly_d   = dly_q;

    case (state_q)
      ST_IDLE: ;
      ST_START: begin
        if (ce) begin
          if (dly_q == DLY_W'(START_DELAY - 1)) begin
            state_d = ST_XFER;
          end else begin
            dly_d = dly_q + 1'b1;
          end
        end
      end
      ST_XFER: begin
        if (ce) begin
          if (index_q == IDX_W'(XFER_LEN - 1)) begin
            state_d = ST_IDLE;
            index_d = '0;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (reg_wr) begin
      page_d  = cpu_wdata;
      index_d = '0;
      dly_d   = '0;
      state_d = ST_START;
    end
  end

  // Bus steering and core read mux, combinational from held state.
  always_comb begin
    mem_addr   = cpu_addr;
    mem_write  = cpu_write & ~hi_sel & ~active;
    mem_wdata  = cpu_wdata;
    hi_addr    = cpu_addr[7:0];
    hi_write   = cpu_write & hi_sel & ~reg_hit;
    oam_addr   = index_q;
    oam_wdata  = mem_rdata;
    oam_we     = 1'b0;
    dma_active = active;

    if (hi_sel) begin
      cpu_rdata = reg_hit ? page_q : hi_rdata;
    end else begin
      cpu_rdata = active ? 8'hFF : mem_rdata;
    end

    if (state_q == ST_XFER) begin
      mem_addr = {src, index_q};
      oam_we   = ce;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter: directed scenarios plus randomized core traffic against a
// transfer-countdown reference model and a byte-level OAM model.
module tb_oam_dma_arbiter;

  localparam logic [15:0] REG = 16'hFF46;
  localparam int XL = 160;
  localparam int SD = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic [15:0] cpu_addr;
  logic        cpu_write;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic        mem_write;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  hi_addr;
  logic        hi_write;
  logic [7:0]  hi_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic        dma_active;

  logic [7:0] mem   [0:65535];
  logic [7:0] hiram [0:255];
  logic [7:0] oam_m [0:XL-1];
  logic [7:0] oam_d [0:XL-1];

  int         checks = 0;
  int         errors = 0;
  int         left   = 0;
  logic [7:0] page_m = 8'h00;
  int         act_cnt;
  logic [7:0]  last_rdata;
  logic [15:0] last_maddr;
  logic        last_xfer;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign hi_rdata  = hiram[hi_addr];

  oam_dma_arbiter dut (
    .clk(clk), .rst(rst_n), .ce(ce),
    .cpu_addr(cpu_addr), .cpu_write(cpu_write), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .hi_addr(hi_addr), .hi_write(hi_write), .hi_rdata(hi_rdata),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we), .dma_active(dma_active)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] src_of(input logic [7:0] p);
    return (p >= 8'hE0) ? p - 8'h20 : p;
  endfunction

  // One ce-cycle: drive, check against the model, capture OAM, clock, advance the model.
  task automatic cyc(input logic c, input logic [15:0] a, input logic w, input logic [7:0] d);
    logic       xfer;
    int         idx;
    logic [7:0] er;
    logic [15:0] sa;
    @(negedge clk);
    ce = c; cpu_addr = a; cpu_write = w; cpu_wdata = d;
    #1;
    xfer = (left > 0) && (left <= XL);
    idx  = XL - left;
    sa   = {src_of(page_m), 8'(idx)};
    if (a[15:8] == 8'hFF) er = (a == REG) ? page_m : hiram[a[7:0]];
    else                  er = (left > 0) ? 8'hFF : mem[a];
    check("dma_active", 16'(dma_active), 16'(left > 0));
    check("mem_addr", mem_addr, xfer ? sa : a);
    check("mem_write", 16'(mem_write), 16'(w && a[15:8] != 8'hFF && left == 0));
    check("hi_write", 16'(hi_write), 16'(w && a[15:8] == 8'hFF && a != REG));
    check("hi_addr", 16'(hi_addr), 16'(a[7:0]));
    check("oam_we", 16'(oam_we), 16'(xfer && c));
    check("cpu_rdata", 16'(cpu_rdata), 16'(er));
    if (xfer) begin
      check("oam_addr", 16'(oam_addr), 16'(idx));
      check("oam_wdata", 16'(oam_wdata), 16'(mem[sa]));
    end
    if (oam_we) begin
      if (oam_addr < 8'(XL)) oam_d[oam_addr] = oam_wdata;
      else check("oam_range", 16'(oam_addr), 16'(XL - 1));
    end
    if (dma_active && c) act_cnt++;
    last_rdata = cpu_rdata;
    last_maddr = mem_addr;
    last_xfer  = xfer;
    @(posedge clk);
    if (c) begin
      if (xfer) oam_m[idx] = mem[sa];
      if (w && a == REG) begin
        page_m = d;
        left   = SD + XL;
      end else if (left > 0) begin
        left--;
      end
    end
  endtask

  // Random core access; FF46 writes are rare and only when allowed.
  task automatic rnd(input bit ce_rand, input bit allow_reg);
    logic [15:0] a;
    logic        w;
    logic        c;
    int          m;
    m = int'($urandom % 4);
    a = 16'($urandom);
    w = 1'($urandom);
    if (m == 0) a = {8'hFF, 8'($urandom)};
    if (m == 1) a = REG;
    if (a == REG) w = allow_reg && ($urandom % 16 == 0);
    c = ce_rand ? ($urandom % 4 != 0) : 1'b1;
    cyc(c, a, w, 8'($urandom));
  endtask

  task automatic run_to_idx(input int target);
    for (int k = 0; k < 400 && !(left > 0 && XL - left == target); k++) rnd(1'b0, 1'b0);
    check("reach_idx", 16'(XL - left), 16'(target));
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && left > 0; k++) rnd(1'b0, 1'b0);
    cyc(1'b1, 16'h0000, 1'b0, 8'h00);
    check("drained", 16'(dma_active), 16'h0000);
  endtask

  task automatic cmp_oam(input string tag);
    for (int i = 0; i < XL; i++) check(tag, 16'(oam_d[i]), 16'(oam_m[i]));
  endtask

  initial begin
    logic [15:0] first_a;
    logic [15:0] last_a;
    bit          seen;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) hiram[i] = 8'($urandom);
    for (int i = 0; i < XL; i++) begin
      mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
      oam_m[i] = 8'h00;
      oam_d[i] = 8'h00;
    end

    // Reset state
    rst_n = 1'b0; ce = 1'b1; cpu_addr = 16'h1234; cpu_write = 1'b1; cpu_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_active", 16'(dma_active), 16'h0000);
    check("rst_oam_we", 16'(oam_we), 16'h0000);
    check("rst_mem_addr", mem_addr, 16'h1234);
    check("rst_mem_write", 16'(mem_write), 16'h0001);
    cpu_addr = REG; cpu_write = 1'b0;
    #1;
    check("rst_page", 16'(cpu_rdata), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1/2: C1 transfer with blocked core accesses mid-XFER
    act_cnt = 0;
    cyc(1'b1, REG, 1'b1, 8'hC1);
    run_to_idx(10);
    cyc(1'b1, 16'hC000, 1'b0, 8'h00);
    check("blk_rd_C000", 16'(last_rdata), 16'h00FF);
    cyc(1'b1, 16'h8000, 1'b1, 8'hAA);
    cyc(1'b1, 16'hFF85, 1'b0, 8'h00);
    check("hi_rd_FF85", 16'(last_rdata), 16'(hiram[8'h85]));
    cyc(1'b1, REG, 1'b0, 8'h00);
    check("reg_rd_C1", 16'(last_rdata), 16'h00C1);
    drain();
    check("active_cycles", 16'(act_cnt), 16'(SD + XL));
    for (int i = 0; i < XL; i++) check("oam_c1", 16'(oam_d[i]), 16'(8'(i) ^ 8'h5A));

    // Scenario 3: echo page FE sources DE00-DE9F
    cyc(1'b1, REG, 1'b1, 8'hFE);
    seen = 1'b0; first_a = 16'h0; last_a = 16'h0;
    for (int k = 0; k < 400 && left > 0; k++) begin
      rnd(1'b0, 1'b0);
      if (last_xfer) begin
        if (!seen) first_a = last_maddr;
        seen = 1'b1;
        last_a = last_maddr;
      end
    end
    check("fe_first", first_a, 16'hDE00);
    check("fe_last", last_a, 16'hDE9F);
    cmp_oam("oam_fe");

    // Scenario 4: restart at index 50 with D0
    act_cnt = 0;
    cyc(1'b1, REG, 1'b1, 8'hC1);
    run_to_idx(50);
    cyc(1'b1, REG, 1'b1, 8'hD0);
    drain();
    check("restart_cycles", 16'(act_cnt), 16'(SD + 51 + SD + XL));
    for (int i = 0; i < XL; i++) check("oam_d0", 16'(oam_d[i]), 16'(mem[16'hD000 + 16'(i)]));

    // Scenario 5: ce held low at index 20
    cyc(1'b1, REG, 1'b1, 8'hC3);
    run_to_idx(20);
    for (int k = 0; k < 7; k++) cyc(1'b0, 16'($urandom), 1'b0, 8'h00);
    check("hold_idx", 16'(oam_addr), 16'd20);
    drain();
    cmp_oam("oam_hold");

    // Scenario 6: async reset at index 80
    cyc(1'b1, REG, 1'b1, 8'hC5);
    run_to_idx(80);
    @(negedge clk);
    ce = 1'b1; cpu_addr = REG; cpu_write = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_active", 16'(dma_active), 16'h0000);
    check("arst_oam_we", 16'(oam_we), 16'h0000);
    check("arst_page", 16'(cpu_rdata), 16'h0000);
    cpu_addr = 16'hC010;
    #1;
    check("arst_mem_addr", mem_addr, 16'hC010);
    check("arst_rd", 16'(cpu_rdata), 16'(mem[16'hC010]));
    left = 0; page_m = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    cmp_oam("oam_partial");

    // Scenario 7: random pages, random ce, random restarts
    for (int r = 0; r < 6; r++) begin
      cyc(1'b1, REG, 1'b1, 8'($urandom));
      for (int k = 0; k < 300; k++) rnd(1'b1, 1'b1);
      drain();
      cmp_oam("oam_rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
